// File: rtl/fp_add_if.sv
`default_nettype none
// ============================================================================
// Module   : fp_add_if
// Brief    : Operand/result handshake bundle for the pipelined FP adder.
//            master = producer/consumer side, slave = adder side.
// Revision : 1.0  initial release
// ============================================================================
interface fp_add_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
);
  localparam int c_w = 1 + EXP_W + MAN_W;

  logic           in_valid;
  logic           in_ready;
  logic [c_w-1:0] a;
  logic [c_w-1:0] b;
  logic           sub;
  logic           out_valid;
  logic           out_ready;
  logic [c_w-1:0] result;
  logic           flag_ovf;
  logic           flag_unf;
  logic           flag_zero;

  modport master (
    output in_valid, a, b, sub, out_ready,
    input  in_ready, out_valid, result, flag_ovf, flag_unf, flag_zero
  );

  modport slave (
    input  in_valid, a, b, sub, out_ready,
    output in_ready, out_valid, result, flag_ovf, flag_unf, flag_zero
  );
endinterface
`default_nettype wire

// File: rtl/fp_add_pipe.sv
`default_nettype none
// ============================================================================
// Module   : fp_add_pipe
// Brief    : Four-stage floating-point adder/subtractor (unpack/swap, align,
//            add, normalise/round/pack) with global-stall valid/ready flow.
//            Denormal inputs flush to zero; exponent all-ones overflows.
//            Macro FP_ADD_ROUND_EN: round-to-nearest-even when defined,
//            truncation toward zero when undefined.
// Revision : 1.0  initial release
// ============================================================================
module fp_add_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic     clk,
  input  logic     rst_n,
  fp_add_if.slave  bus
);
  localparam int c_w   = 1 + EXP_W + MAN_W;
  localparam int c_xw  = MAN_W + 4;                  // hidden+fraction+G+R+S
  localparam int c_lzw = $clog2(MAN_W + 5);
  localparam int c_ew  = ((EXP_W > c_lzw) ? EXP_W : c_lzw) + 2;
  localparam logic signed [c_ew-1:0] c_one     = c_ew'(1);
  localparam logic signed [c_ew-1:0] c_zero    = '0;
  localparam logic signed [c_ew-1:0] c_exp_ovf = c_ew'((1 << EXP_W) - 1);

  logic w_adv;
  assign w_adv        = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = w_adv;

  // ---------------- S1: unpack, flush, compare, swap ----------------
  logic [EXP_W-1:0] w_ea, w_eb;
  logic [MAN_W:0]   w_ma, w_mb;
  logic             w_sa, w_sb, w_a_ge_b;
  assign w_ea     = bus.a[c_w-2 -: EXP_W];
  assign w_eb     = bus.b[c_w-2 -: EXP_W];
  assign w_ma     = (w_ea == '0) ? '0 : {1'b1, bus.a[MAN_W-1:0]};
  assign w_mb     = (w_eb == '0) ? '0 : {1'b1, bus.b[MAN_W-1:0]};
  assign w_sa     = bus.a[c_w-1];
  assign w_sb     = bus.b[c_w-1] ^ bus.sub;
  assign w_a_ge_b = {w_ea, w_ma} >= {w_eb, w_mb};

  logic             r1_valid, r1_sign, r1_eff_sub;
  logic [EXP_W-1:0] r1_exp_l, r1_exp_s;
  logic [MAN_W:0]   r1_man_l, r1_man_s;

  // Capture the swapped operand pair so L always holds the larger magnitude.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r1_valid <= 1'b0;
    end else if (w_adv) begin
      r1_valid   <= bus.in_valid;
      r1_sign    <= w_a_ge_b ? w_sa : w_sb;
      r1_eff_sub <= w_sa ^ w_sb;
      r1_exp_l   <= w_a_ge_b ? w_ea : w_eb;
      r1_exp_s   <= w_a_ge_b ? w_eb : w_ea;
      r1_man_l   <= w_a_ge_b ? w_ma : w_mb;
      r1_man_s   <= w_a_ge_b ? w_mb : w_ma;
    end
  end

  // ---------------- S2: align smaller operand ----------------
  logic [EXP_W-1:0]         w_diff;
  logic [2*(MAN_W+3)-1:0]   w_wide, w_shifted;
  logic [c_xw-1:0]          w_s_al;
  assign w_diff    = r1_exp_l - r1_exp_s;
  assign w_wide    = {r1_man_s, 2'b00, {(MAN_W+3){1'b0}}};
  assign w_shifted = w_wide >> w_diff;

  // Upper half is the aligned S with G/R; everything below collapses to sticky.
  always_comb begin
    w_s_al = '0;
    if (32'(w_diff) >= MAN_W + 3)
      w_s_al = {{(MAN_W+3){1'b0}}, |r1_man_s};
    else
      w_s_al = {w_shifted[2*(MAN_W+3)-1 -: (MAN_W+3)], |w_shifted[MAN_W+2:0]};
  end

  logic             r2_valid, r2_sign, r2_eff_sub;
  logic [EXP_W-1:0] r2_exp;
  logic [c_xw-1:0]  r2_man_l, r2_man_s;

  // Register the aligned operand pair.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r2_valid <= 1'b0;
    end else if (w_adv) begin
      r2_valid   <= r1_valid;
      r2_sign    <= r1_sign;
      r2_eff_sub <= r1_eff_sub;
      r2_exp     <= r1_exp_l;
      r2_man_l   <= {r1_man_l, 3'b000};
      r2_man_s   <= w_s_al;
    end
  end

  // ---------------- S3: magnitude add / subtract ----------------
  logic [c_xw:0] w_sum;
  assign w_sum = r2_eff_sub ? ({1'b0, r2_man_l} - {1'b0, r2_man_s})
                            : ({1'b0, r2_man_l} + {1'b0, r2_man_s});

  logic             r3_valid, r3_sign;
  logic [EXP_W-1:0] r3_exp;
  logic [c_xw:0]    r3_sum;

  // Register the raw sum; L >= S so subtraction never goes negative.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r3_valid <= 1'b0;
    end else if (w_adv) begin
      r3_valid <= r2_valid;
      r3_sign  <= r2_sign;
      r3_exp   <= r2_exp;
      r3_sum   <= w_sum;
    end
  end

  // ---------------- S4: normalise, round, pack ----------------
  logic [c_lzw-1:0]        w_lzc;
  logic [c_xw-1:0]         w_norm;
  logic signed [c_ew-1:0]  w_exp_n, w_exp_r;
  logic [MAN_W+1:0]        w_man_r;
  logic                    w_inc, w_unused_bits;
  logic [c_w-1:0]          w_result;
  logic                    w_ovf, w_unf, w_zero;

  // Leading-zero count of the non-carry sum; highest set bit wins.
  always_comb begin
    w_lzc = '0;
    for (int i = 0; i < c_xw; i++)
      if (r3_sum[i]) w_lzc = c_lzw'(c_xw - 1 - i);
  end

  // Carry-out shifts right keeping the lost bit in sticky, else shift left.
  always_comb begin
    w_norm  = '0;
    w_exp_n = $signed({{(c_ew-EXP_W){1'b0}}, r3_exp});
    if (r3_sum[c_xw]) begin
      w_norm  = {r3_sum[c_xw:2], r3_sum[1] | r3_sum[0]};
      w_exp_n = w_exp_n + c_one;
    end else begin
      w_norm  = r3_sum[c_xw-1:0] << w_lzc;
      w_exp_n = w_exp_n - $signed({{(c_ew-c_lzw){1'b0}}, w_lzc});
    end
  end

`ifdef FP_ADD_ROUND_EN
  assign w_inc         = w_norm[2] & (w_norm[1] | w_norm[0] | w_norm[3]);
  assign w_unused_bits = w_man_r[MAN_W];
`else
  assign w_inc         = 1'b0;
  assign w_unused_bits = ^{w_man_r[MAN_W], w_norm[2:0]};
`endif
  assign w_man_r = {1'b0, w_norm[c_xw-1:3]} + {{(MAN_W+1){1'b0}}, w_inc};
  assign w_exp_r = w_man_r[MAN_W+1] ? (w_exp_n + c_one) : w_exp_n;

  // Special-case selection: zero, overflow, flushed underflow, normal pack.
  always_comb begin
    w_result = '0;
    w_ovf    = 1'b0;
    w_unf    = 1'b0;
    w_zero   = 1'b0;
    if (r3_sum == '0) begin
      w_zero = 1'b1;
    end else if (w_exp_r >= c_exp_ovf) begin
      w_result = {r3_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      w_ovf    = 1'b1;
    end else if (w_exp_r <= c_zero) begin
      w_unf = 1'b1;
    end else begin
      w_result = {r3_sign, w_exp_r[EXP_W-1:0],
                  w_man_r[MAN_W+1] ? {MAN_W{1'b0}} : w_man_r[MAN_W-1:0]};
    end
  end

  // Output register: holds while stalled, loads only real operations.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.result    <= '0;
      bus.flag_ovf  <= 1'b0;
      bus.flag_unf  <= 1'b0;
      bus.flag_zero <= 1'b0;
    end else if (w_adv) begin
      bus.out_valid <= r3_valid;
      if (r3_valid) begin
        bus.result    <= w_result;
        bus.flag_ovf  <= w_ovf;
        bus.flag_unf  <= w_unf;
        bus.flag_zero <= w_zero;
      end
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_fp_add_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp_add_pipe
// Brief    : Directed self-checking bench for fp_add_pipe (EXP_W=8, MAN_W=23).
//            Expected rounding result follows FP_ADD_ROUND_EN.
// Revision : 1.0  initial release
// ============================================================================
module tb_fp_add_pipe;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fp_add_if #(.EXP_W(8), .MAN_W(23)) bus ();

  fp_add_pipe #(.EXP_W(8), .MAN_W(23)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] flags();
    return {29'd0, bus.flag_ovf, bus.flag_unf, bus.flag_zero};
  endfunction

  // One isolated operation: checks in_ready, 4-cycle latency, result, flags.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic sub, input logic [31:0] er, input logic [2:0] ef);
    int lat;
    @(negedge clk);
    bus.a = a; bus.b = b; bus.sub = sub; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    #1 check({tag, "_in_ready"}, {31'd0, bus.in_ready}, 32'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 12) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, lat, 32'd4);
    check({tag, "_result"}, bus.result, er);
    check({tag, "_flags"}, flags(), {29'd0, ef});
  endtask

  logic [31:0] va [8];
  logic [31:0] vb [8];
  logic [31:0] ve [8];
  logic        vs [8];
  logic [31:0] rnd_exp;
  logic [31:0] prev_res;
  logic        prev_stall;
  logic        stale;
  int          snd, rcv;

  initial begin
    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.sub = 1'b0; bus.out_ready = 1'b1;
`ifdef FP_ADD_ROUND_EN
    rnd_exp = 32'h3F80_0001;
`else
    rnd_exp = 32'h3F80_0000;
`endif
    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_result", bus.result, 32'd0);
    check("rst_flags", flags(), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1 check("post_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);

    // Directed single operations
    run_op("add_1_1",    32'h3F80_0000, 32'h3F80_0000, 1'b0, 32'h4000_0000, 3'b000);
    run_op("sub_15_05",  32'h3FC0_0000, 32'h3F00_0000, 1'b1, 32'h3F80_0000, 3'b000);
    run_op("cancel",     32'h3F80_0001, 32'h3F80_0001, 1'b1, 32'h0000_0000, 3'b001);
    run_op("overflow",   32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b0, 32'h7F80_0000, 3'b100);
    run_op("round_tie",  32'h3F80_0000, 32'h3380_0000, 1'b0, 32'h3F80_0000, 3'b000);
    run_op("round_up",   32'h3F80_0000, 32'h33C0_0000, 1'b0, rnd_exp,       3'b000);
    run_op("underflow",  32'h0080_0000, 32'h0080_0001, 1'b1, 32'h0000_0000, 3'b010);
    run_op("denorm_fz",  32'h0000_0001, 32'h3F80_0000, 1'b0, 32'h3F80_0000, 3'b000);

    // Backpressure stream: 8 back-to-back pairs, out_ready low cycles 5..9
    va[0]=32'h3F80_0000; vb[0]=32'h3F80_0000; vs[0]=0; ve[0]=32'h4000_0000; // 1+1
    va[1]=32'h4000_0000; vb[1]=32'h3F80_0000; vs[1]=0; ve[1]=32'h4040_0000; // 2+1
    va[2]=32'h4040_0000; vb[2]=32'h3F80_0000; vs[2]=1; ve[2]=32'h4000_0000; // 3-1
    va[3]=32'h4080_0000; vb[3]=32'h4080_0000; vs[3]=0; ve[3]=32'h4100_0000; // 4+4
    va[4]=32'h3F00_0000; vb[4]=32'h3F00_0000; vs[4]=0; ve[4]=32'h3F80_0000; // .5+.5
    va[5]=32'h4120_0000; vb[5]=32'h3F80_0000; vs[5]=0; ve[5]=32'h4130_0000; // 10+1
    va[6]=32'h40A0_0000; vb[6]=32'h4040_0000; vs[6]=1; ve[6]=32'h4000_0000; // 5-3
    va[7]=32'hC000_0000; vb[7]=32'hC000_0000; vs[7]=0; ve[7]=32'hC080_0000; // -2+-2
    snd = 0; rcv = 0; prev_stall = 1'b0; prev_res = '0;
    for (int cyc = 0; cyc < 60 && rcv < 8; cyc++) begin
      @(negedge clk);
      bus.in_valid = (snd < 8);
      if (snd < 8) begin
        bus.a = va[snd]; bus.b = vb[snd]; bus.sub = vs[snd];
      end
      bus.out_ready = !(cyc >= 5 && cyc <= 9);
      #1;
      if (prev_stall) check("bp_hold", bus.result, prev_res);
      if (bus.out_valid && !bus.out_ready)
        check("bp_in_ready_low", {31'd0, bus.in_ready}, 32'd0);
      if (bus.out_valid && bus.out_ready) begin
        check($sformatf("bp_res%0d", rcv), bus.result, ve[rcv]);
        rcv++;
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_res   = bus.result;
      if (bus.in_valid && bus.in_ready) snd++;
    end
    check("bp_count", rcv, 32'd8);
    @(negedge clk);
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    #1 check("bp_no_extra", {31'd0, bus.out_valid}, 32'd0);

    // Reset mid-flight: three pairs, reset on the third cycle
    @(negedge clk);
    bus.in_valid = 1'b1; bus.a = 32'h3F80_0000; bus.b = 32'h3F80_0000; bus.sub = 1'b0;
    @(negedge clk);
    bus.a = 32'h4000_0000; bus.b = 32'h3F80_0000;
    @(negedge clk);
    bus.a = 32'h4080_0000; bus.b = 32'h4080_0000;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; bus.in_valid = 1'b0;
    #1;
    check("mid_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("mid_rst_result", bus.result, 32'd0);
    check("mid_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    stale = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      #1 if (bus.out_valid) stale = 1'b1;
    end
    check("mid_rst_no_stale", {31'd0, stale}, 32'd0);
    run_op("after_rst", 32'h4040_0000, 32'h3F80_0000, 1'b0, 32'h4080_0000, 3'b000);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
`default_nettype wire
